usb2_ulpi_reg_arb: RTL

USB2_ULPI_REG_ARB -- requirements
Module: usb2_ulpi_reg_arb

---
 rtl/usb2_ulpi_reg_arb.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/usb2_ulpi_reg_arb.sv
// usb2_ulpi_reg_arb: round-robin arbiter that lets three requesters share one
// ULPI register engine. A transaction is granted, issued, and then waited on.
// If it times out it is re-issued up to MAX_RETRY times, and the result is
// returned to the granted requester as a one-cycle ack (qualified by err).
module usb2_ulpi_reg_arb #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic        phy_clk,
  input  logic        reset,
  input  logic [2:0]  rq_req,
  input  logic [2:0]  rq_we,
  input  logic [23:0] rq_addr,
  input  logic [23:0] rq_wdata,
  output logic [2:0]  rq_ack,
  output logic [2:0]  rq_err,
  output logic [7:0]  rq_rdata,
  output logic        reg_go,
  output logic        reg_we,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  input  logic        reg_done,
  input  logic [7:0]  reg_rdata,
  input  logic        reg_busy
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_TOP   = TW'(TIMEOUT);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          we_q, we_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    retry_q, retry_d;
  logic          go_q, go_d;
  logic [1:0]    pick;

  // Round-robin pick: search starts at the requester after the last grant.
  // The loop runs from the farthest candidate down so that the nearest one wins.
  always_comb begin
    pick = grant_q;
    for (int k = 2; k >= 0; k--) begin
      if (rq_req[(int'(grant_q) + 1 + k) % 3]) pick = 2'((int'(grant_q) + 1 + k) % 3);
    end
  end

  // Next-state logic: arbitrate, issue, wait with timeout/retry, respond.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    go_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|rq_req) begin
          grant_d = pick;
          we_d    = rq_we[pick];
          addr_d  = rq_addr[{pick, 3'b000} +: 8];
          wdata_d = rq_wdata[{pick, 3'b000} +: 8];
          rdata_d = 8'h00;
          err_d   = 1'b0;
          retry_d = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!reg_busy) begin
          go_d    = 1'b1;
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (reg_done) begin
          if (!we_q) rdata_d = reg_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d = TMO_TOP;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            state_d = ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'd2;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      retry_q <= 2'd0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      go_q    <= go_d;
    end
  end

  // Output decode: response fields are only driven during RESP.
  always_comb begin
    rq_ack    = 3'b000;
    rq_err    = 3'b000;
    rq_rdata  = 8'h00;
    if (state_q == RESP) begin
      rq_ack   = 3'b001 << grant_q;
      rq_err   = err_q ? (3'b001 << grant_q) : 3'b000;
      rq_rdata = rdata_q;
    end
    reg_go    = go_q;
    reg_we    = we_q;
    reg_addr  = addr_q;
    reg_wdata = wdata_q;
  end

endmodule
